// File: rtl/led_gui_key_encoder.sv
// led_gui_key_encoder: four raw active-low buttons -> debounced levels and one-hot command pulses
//   clk        system clock
//   rst_n      synchronous reset, active low
//   key_in     raw buttons, active low, asynchronous
//   config_sig one-hot (or zero) single-cycle command pulses
//   key_level  debounced key state, 1 = pressed
//   busy       high while an event is still waiting to be emitted
module led_gui_key_encoder #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic [3:0] config_sig,
  output logic [3:0] key_level,
  output logic       busy
);
  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CW-1:0] D_END = CW'(DEBOUNCE_CYC - 1);
  localparam logic [31:0] H_END = 32'(HOLD_CYC - 1);
  localparam logic [31:0] R_END = 32'(REPEAT_CYC - 1);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  logic [3:0] s1_q, s2_q, lvl_q, lvl_d, prv_q, arm_q, arm_d;
  logic [3:0] pend_q, pend_d, cfg_q, cfg_d, rep_q, rep_d, all_ev, hkm;
  logic [1:0] vld_q, hk_q, hk_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [31:0] rc_q, rc_d;
  logic busy_q, busy_d;
  state_t st_q, st_d;
  // s2_q is active low, so the synced press differs from the level when they are equal
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 4; i++) begin
      lvl_d[i] = (s2_q[i] == lvl_q[i] && cnt_q[i] == D_END) ? ~lvl_q[i] : lvl_q[i];
      cnt_d[i] = (s2_q[i] != lvl_q[i] || cnt_q[i] == D_END) ? '0 : cnt_q[i] + 1'b1;
    end
  end
  // A key only arms once the synchroniser carries real data showing it released,
  // so a button held across reset stays silent until released and pressed again.
  assign arm_d = arm_q | (vld_q[1] ? s2_q : 4'b0);
  assign hkm = 4'b0001 << hk_q;
  always_comb begin
    st_d  = st_q;
    rc_d  = rc_q;
    hk_d  = hk_q;
    rep_d = '0;
    if (st_q == IDLE) begin
      if ($onehot(lvl_q) && |(lvl_q & arm_q)) begin
        st_d = HOLD;
        rc_d = '0;
        hk_d = {lvl_q[3] | lvl_q[2], lvl_q[3] | lvl_q[1]};
      end
    end else if (lvl_q != hkm) begin
      st_d = IDLE;
      rc_d = '0;
    end else if (rc_q == ((st_q == HOLD) ? H_END : R_END)) begin
      st_d  = REPEAT;
      rc_d  = '0;
      rep_d = hkm;
    end else begin
      rc_d = rc_q + 32'd1;
    end
  end
  // Pending events and fresh events merge, then the lowest set bit leaves this cycle.
  assign all_ev = pend_q | (lvl_q & ~prv_q & arm_q) | rep_q;
  assign cfg_d  = all_ev & (~all_ev + 4'd1);
  assign pend_d = all_ev & ~cfg_d;
  assign busy_d = |pend_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 4'b1111;
      s2_q   <= 4'b1111;
      vld_q  <= '0;
      lvl_q  <= '0;
      prv_q  <= '0;
      arm_q  <= '0;
      pend_q <= '0;
      cfg_q  <= '0;
      rep_q  <= '0;
      busy_q <= 1'b0;
      st_q   <= IDLE;
      rc_q   <= '0;
      hk_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= key_in;
      s2_q   <= s1_q;
      vld_q  <= {vld_q[0], 1'b1};
      lvl_q  <= lvl_d;
      prv_q  <= lvl_q;
      arm_q  <= arm_d;
      pend_q <= pend_d;
      cfg_q  <= cfg_d;
      rep_q  <= rep_d;
      busy_q <= busy_d;
      st_q   <= st_d;
      rc_q   <= rc_d;
      hk_q   <= hk_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign config_sig = cfg_q;
  assign key_level  = lvl_q;
  assign busy       = busy_q;
endmodule
